wb_sched: RTL and testbench

- Write-back sequencer for the register-bank data-source mux.
- Accepts one write-back request (source code and destination register) from the main control unit.
- Drives the mux select and holds it stable while the chosen source is not ready. It then issues a single-cycle register write and acknowledges the requester.
- Sits between the main control FSM and the DataSrc mux / register bank.

---
 rtl/wb_sched_pkg.sv | 23 ++
 rtl/wb_sched_if.sv | 34 +++
 rtl/wb_src_ready.sv | 23 ++
 rtl/wb_sched.sv | 128 ++++++++++++
 tb/tb_wb_sched.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/wb_sched_pkg.sv
// Shared constants for the write-back sequencer: source codes, state encoding
// and bus widths. Imported by the interface, the ready decoder and the top.
package wb_pkg;

  localparam int SRC_W = 3;
  localparam int DST_W = 5;

  localparam logic [SRC_W-1:0] SRC_LS      = 3'd0;
  localparam logic [SRC_W-1:0] SRC_HI      = 3'd1;
  localparam logic [SRC_W-1:0] SRC_LO      = 3'd2;
  localparam logic [SRC_W-1:0] SRC_SHIFT   = 3'd3;
  localparam logic [SRC_W-1:0] SRC_C227    = 3'd4;
  localparam logic [SRC_W-1:0] SRC_SEXT    = 3'd5;
  localparam logic [SRC_W-1:0] SRC_ALU     = 3'd6;
  localparam logic [SRC_W-1:0] SRC_ILLEGAL = 3'd7;

  localparam logic [SRC_W-1:0] SEL_RESET = SRC_ALU;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

endpackage

// File: rtl/wb_sched_if.sv
// Bus between the main control FSM (master) and the write-back sequencer
// (slave), including the source-ready lines and the mux/register-bank outputs.
interface wb_sched_if;
  import wb_pkg::*;

  logic                 wb_req;
  logic [SRC_W-1:0]     wb_src;
  logic [DST_W-1:0]     wb_dst;
  logic                 ls_ready;
  logic                 muldiv_busy;
  logic                 shift_ready;

  logic [SRC_W-1:0]     data_src_control;
  logic                 reg_write;
  logic [DST_W-1:0]     reg_dst;
  logic                 wb_ack;
  logic                 busy;
  logic                 err_illegal;
  logic                 err_overrun;
  logic                 err_timeout;

  modport master (
    output wb_req, wb_src, wb_dst, ls_ready, muldiv_busy, shift_ready,
    input  data_src_control, reg_write, reg_dst, wb_ack, busy,
           err_illegal, err_overrun, err_timeout
  );

  modport slave (
    input  wb_req, wb_src, wb_dst, ls_ready, muldiv_busy, shift_ready,
    output data_src_control, reg_write, reg_dst, wb_ack, busy,
           err_illegal, err_overrun, err_timeout
  );

endinterface

// File: rtl/wb_src_ready.sv
// Combinational decode: is the data behind a given mux source valid right now?
module wb_src_ready
  import wb_pkg::*;
(
  input  logic [SRC_W-1:0] src,
  input  logic             ls_ready,
  input  logic             muldiv_busy,
  input  logic             shift_ready,
  output logic             ready
);

  always_comb begin
    ready = 1'b0;
    case (src)
      SRC_LS:                      ready = ls_ready;
      SRC_HI, SRC_LO:              ready = !muldiv_busy;
      SRC_SHIFT:                   ready = shift_ready;
      SRC_C227, SRC_SEXT, SRC_ALU: ready = 1'b1;
      default:                     ready = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_sched.sv
// Write-back sequencer: holds the DataSrc mux select until the source is ready,
// then issues one register write and acks. WB_TIMEOUT_EN enables WAIT abort.
module wb_sched
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic      clk,
  input  logic      reset_n,
  wb_sched_if.slave bus
);

  logic [1:0]       state_q, state_d;
  logic [SRC_W-1:0] sel_q, sel_d;
  logic [DST_W-1:0] dst_q, dst_d;
  logic             reg_write_q, reg_write_d;
  logic             ack_q, ack_d;
  logic             err_ill_q, err_ill_d;
  logic             err_ovr_q, err_ovr_d;
  logic             err_to_q, err_to_d;
  logic             src_ready;

  wb_src_ready u_ready (
    .src         (sel_q),
    .ls_ready    (bus.ls_ready),
    .muldiv_busy (bus.muldiv_busy),
    .shift_ready (bus.shift_ready),
    .ready       (src_ready)
  );

`ifdef WB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timed_out;
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`endif

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    dst_d       = dst_q;
    reg_write_d = 1'b0;
    ack_d       = 1'b0;
    err_ill_d   = 1'b0;
    err_ovr_d   = 1'b0;
    err_to_d    = 1'b0;
`ifdef WB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.wb_req) begin
          if (bus.wb_src == SRC_ILLEGAL) begin
            err_ill_d = 1'b1;
          end else begin
            sel_d   = bus.wb_src;
            dst_d   = bus.wb_dst;
            state_d = ST_WAIT;
`ifdef WB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      ST_WAIT: begin
        err_ovr_d = bus.wb_req;
        if (src_ready) begin
          state_d     = ST_WRITE;
          ack_d       = 1'b1;
          reg_write_d = (dst_q != '0);
`ifdef WB_TIMEOUT_EN
        end else if (timed_out) begin
          // Abort: ack the requester but never write stale mux data.
          state_d  = ST_WRITE;
          ack_d    = 1'b1;
          err_to_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      ST_WRITE: begin
        err_ovr_d = bus.wb_req;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= SEL_RESET;
      dst_q       <= '0;
      reg_write_q <= 1'b0;
      ack_q       <= 1'b0;
      err_ill_q   <= 1'b0;
      err_ovr_q   <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      dst_q       <= dst_d;
      reg_write_q <= reg_write_d;
      ack_q       <= ack_d;
      err_ill_q   <= err_ill_d;
      err_ovr_q   <= err_ovr_d;
      err_to_q    <= err_to_d;
    end
  end

`ifdef WB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`endif

  assign bus.data_src_control = sel_q;
  assign bus.reg_dst          = dst_q;
  assign bus.reg_write        = reg_write_q;
  assign bus.wb_ack           = ack_q;
  assign bus.busy             = (state_q != ST_IDLE);
  assign bus.err_illegal      = err_ill_q;
  assign bus.err_overrun      = err_ovr_q;
  assign bus.err_timeout      = err_to_q;

endmodule

// File: tb/tb_wb_sched.sv
// Self-checking bench for wb_sched: directed scenarios plus random traffic,
// compared every cycle against a transaction-level reference model.
module tb_wb_sched;

  localparam int TIMEOUT = 4;
`ifdef WB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  wb_sched_if bus ();

  wb_sched #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(7)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: one outstanding transaction, either waiting or writing.
  bit       m_waiting, m_writing;
  int       m_sel, m_dst, m_waited;
  bit       m_ack, m_regw, m_ill, m_ovr, m_to;

  function automatic bit source_valid(int src, bit ls, bit mb, bit sh);
    if (src == 0) return ls;
    if (src == 1 || src == 2) return !mb;
    if (src == 3) return sh;
    return (src >= 4 && src <= 6);
  endfunction

  task automatic model_reset();
    m_waiting = 0; m_writing = 0; m_sel = 6; m_dst = 0; m_waited = 0;
    m_ack = 0; m_regw = 0; m_ill = 0; m_ovr = 0; m_to = 0;
  endtask

  task automatic model_step(bit req, int src, int dst, bit ls, bit mb, bit sh);
    m_ack = 0; m_regw = 0; m_ill = 0; m_ovr = 0; m_to = 0;
    if (m_writing) begin
      m_ovr = req;
      m_writing = 0;
    end else if (m_waiting) begin
      m_ovr = req;
      if (source_valid(m_sel, ls, mb, sh)) begin
        m_waiting = 0; m_writing = 1; m_ack = 1; m_regw = (m_dst != 0);
      end else if (TO_EN && m_waited == TIMEOUT) begin
        m_waiting = 0; m_writing = 1; m_ack = 1; m_to = 1;
      end else begin
        m_waited++;
      end
    end else if (req) begin
      if (src == 7) m_ill = 1;
      else begin
        m_sel = src; m_dst = dst; m_waited = 0; m_waiting = 1;
      end
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, act, exp);
    end
  endtask

  task automatic check_all();
    check_output("data_src_control", 32'(bus.data_src_control), 32'(m_sel));
    check_output("reg_dst", 32'(bus.reg_dst), 32'(m_dst));
    check_output("reg_write", 32'(bus.reg_write), 32'(m_regw));
    check_output("wb_ack", 32'(bus.wb_ack), 32'(m_ack));
    check_output("busy", 32'(bus.busy), 32'(m_waiting || m_writing));
    check_output("err_illegal", 32'(bus.err_illegal), 32'(m_ill));
    check_output("err_overrun", 32'(bus.err_overrun), 32'(m_ovr));
    check_output("err_timeout", 32'(bus.err_timeout), 32'(m_to));
  endtask

  // One clock: check what the last edge produced, then drive the next inputs.
  task automatic apply_stimulus(bit req, int src, int dst, bit ls, bit mb, bit sh);
    @(negedge clk);
    cyc++;
    check_all();
    bus.wb_req      = req;
    bus.wb_src      = 3'(src);
    bus.wb_dst      = 5'(dst);
    bus.ls_ready    = ls;
    bus.muldiv_busy = mb;
    bus.shift_ready = sh;
    model_step(req, src, dst, ls, mb, sh);
  endtask

  task automatic idle(int n, bit ls = 0, bit mb = 0, bit sh = 0);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, ls, mb, sh);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    cyc++;
    check_all();
    #2 reset_n = 1'b0;
    bus.wb_req = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    check_all();
    reset_n = 1'b1;
  endtask

  initial begin
    bus.wb_req = 0; bus.wb_src = 0; bus.wb_dst = 0;
    bus.ls_ready = 0; bus.muldiv_busy = 0; bus.shift_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset_n = 1'b1;

    // ALU source, minimum latency
    apply_stimulus(1, 6, 8, 0, 0, 0);
    idle(3);

    // HI held off by muldiv_busy
    apply_stimulus(1, 1, 5, 0, 1, 0);
    idle(10, 0, 1, 0);
    idle(4);

    // constant source to $zero: ack without write
    apply_stimulus(1, 4, 0, 0, 0, 0);
    idle(3);

    // illegal source, then overrun while waiting on LS
    apply_stimulus(1, 7, 3, 0, 0, 0);
    idle(2);
    apply_stimulus(1, 0, 9, 0, 0, 0);
    apply_stimulus(1, 2, 17, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0, 0);
    apply_stimulus(1, 5, 11, 0, 0, 0);
    apply_stimulus(1, 6, 13, 0, 0, 0);
    idle(3);

    // LS never ready: timeout (or stuck busy without the feature)
    apply_stimulus(1, 0, 12, 0, 0, 0);
    idle(10);
    idle(4, 1, 0, 0);

    // ready pulse in IDLE is not remembered
    apply_stimulus(0, 0, 0, 0, 0, 1);
    apply_stimulus(1, 3, 2, 0, 0, 0);
    idle(2);
    idle(2, 0, 0, 1);

    // reset during WAIT, then shift-register transaction
    apply_stimulus(1, 2, 7, 0, 1, 0);
    idle(2, 0, 1, 0);
    reset_mid();
    apply_stimulus(1, 3, 20, 0, 0, 0);
    idle(3);
    idle(3, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit req;
      int dst;
      req = ($urandom_range(0, 2) == 0);
      dst = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
      apply_stimulus(req, int'($urandom_range(0, 7)), dst,
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 299) == 0) reset_mid();
    end
    idle(2, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
